// File: rtl/udp_tx_engine.sv
// udp_tx_engine: round-robin FIFO-to-GMII UDP/IPv4 frame generator.
// Ports:
//   e_rxc           in   sole clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   fifo_data       in   8*NUM_CH  FWFT read data, channel k at [8k+7:8k]
//   fifo_data_count in  11*NUM_CH  fill level, channel k at [11k+10:11k]
//   fifo_rd_en      out  NUM_CH    one-hot read strobe (byte used same cycle)
//   e_txen/e_txd    out  GMII transmit enable / data (registered)
//   e_txer          out  GMII transmit error, tied low
//   busy            out  high from arbitration through inter-frame gap
//   cur_ch          out  channel of the frame in progress
module udp_tx_engine #(
   parameter int          NUM_CH      = 2,
   parameter int          PAYLOAD_LEN = 1024,
   parameter int          IFG_CYCLES  = 12,
   parameter logic [47:0] SRC_MAC     = 48'h000A_3501_FEC0,
   parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
   parameter logic [31:0] SRC_IP      = {8'd192, 8'd168, 8'd0, 8'd2},
   parameter logic [31:0] DST_IP      = {8'd192, 8'd168, 8'd0, 8'd3},
   parameter logic [15:0] SRC_PORT    = 16'd8080,
   parameter logic [15:0] DST_PORT    = 16'd8080
) (
   input  logic                   e_rxc,
   input  logic                   reset_n,
   input  logic [8*NUM_CH-1:0]    fifo_data,
   input  logic [11*NUM_CH-1:0]   fifo_data_count,
   output logic [NUM_CH-1:0]      fifo_rd_en,
   output logic                   e_txen,
   output logic [7:0]             e_txd,
   output logic                   e_txer,
   output logic                   busy,
   output logic [2:0]             cur_ch
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ARB,
      S_PRE,
      S_ETH,
      S_IP,
      S_UDP,
      S_APP,
      S_PAY,
      S_FCS,
      S_IFG
   } state_t;

   localparam int            CW       = 16;
   localparam logic [15:0]   IP_LEN   = 16'(PAYLOAD_LEN + 32);
   localparam logic [15:0]   UDP_LEN  = 16'(PAYLOAD_LEN + 12);
   localparam logic [10:0]   THRESH   = 11'(PAYLOAD_LEN);
   localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_LEN - 1);
   localparam logic [CW-1:0] IFG_LAST =
      (IFG_CYCLES > 0) ? CW'(IFG_CYCLES - 1) : '0;
   localparam logic [111:0]  ETH_HDR  = {DST_MAC, SRC_MAC, 16'h0800};
   localparam logic [63:0]   UDP_HDR  = {SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};

   // Reflected CRC-32, one byte per call.
   function automatic logic [31:0] crc_step(
      input logic [31:0] crc,
      input logic [7:0]  data
   );
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   // Only the id word varies between frames; all other header words
   // are parameters, so the sum is a cheap adder tree.
   function automatic logic [15:0] ip_csum(input logic [15:0] id);
      logic [31:0] s;
      s = 32'h4500 + 32'(IP_LEN) + 32'(id) + 32'h4000 + 32'h4011
        + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
        + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return ~s[15:0];
   endfunction

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [2:0]               ch_q, ch_d;
   logic [2:0]               rr_q, rr_d;
   logic [15:0]              id_q, id_d;
   logic [NUM_CH-1:0][15:0]  fidx_q, fidx_d;
   logic [15:0]              csum_q, csum_d;
   logic [31:0]              crc_q, crc_d;
   logic [7:0]               txd_q, txd_d;
   logic                     txen_q, txen_d;
   logic                     busy_q, busy_d;

   logic [NUM_CH-1:0]        elig;
   logic [NUM_CH-1:0]        ch_onehot;
   logic                     gnt_vld;
   logic [2:0]               gnt_ch;
   logic [CW-1:0]            last_cnt;
   logic                     cnt_last;
   logic [7:0]               pay_byte;
   logic [15:0]              cur_idx;
   logic [159:0]             ip_hdr;
   logic [31:0]              app_hdr;
   logic [111:0]             eth_sh;
   logic [159:0]             ip_sh;
   logic [63:0]              udp_sh;
   logic [31:0]              app_sh;
   logic [31:0]              fcs_sh;
   logic                     crc_en;

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         elig[k]      = fifo_data_count[11*k +: 11] >= THRESH;
         ch_onehot[k] = (ch_q == 3'(k));
      end
   end

   // Round robin: first eligible channel at or above the pointer,
   // otherwise wrap and take the first one below it.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = 3'd0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!gnt_vld && elig[k] && (3'(k) >= rr_q)) begin
            gnt_vld = 1'b1;
            gnt_ch  = 3'(k);
         end
      end
      for (int k = 0; k < NUM_CH; k++) begin
         if (!gnt_vld && elig[k] && (3'(k) < rr_q)) begin
            gnt_vld = 1'b1;
            gnt_ch  = 3'(k);
         end
      end
   end

   always_comb begin
      pay_byte = 8'h00;
      cur_idx  = 16'h0000;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_onehot[k]) begin
            pay_byte = fifo_data[8*k +: 8];
            cur_idx  = fidx_q[k];
         end
      end
   end

   always_comb begin
      last_cnt = '0;
      unique case (state_q)
         S_PRE:   last_cnt = CW'(7);
         S_ETH:   last_cnt = CW'(13);
         S_IP:    last_cnt = CW'(19);
         S_UDP:   last_cnt = CW'(7);
         S_APP:   last_cnt = CW'(3);
         S_PAY:   last_cnt = PAY_LAST;
         S_FCS:   last_cnt = CW'(3);
         S_IFG:   last_cnt = IFG_LAST;
         default: last_cnt = '0;
      endcase
   end

   assign cnt_last = (cnt_q == last_cnt);

   // State register
   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         S_IDLE: if (|elig) state_d = S_ARB;
         S_ARB:  state_d = gnt_vld ? S_PRE : S_IDLE;
         default: begin
            if (!cnt_last) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               unique case (state_q)
                  S_PRE:   state_d = S_ETH;
                  S_ETH:   state_d = S_IP;
                  S_IP:    state_d = S_UDP;
                  S_UDP:   state_d = S_APP;
                  S_APP:   state_d = S_PAY;
                  S_PAY:   state_d = S_FCS;
                  S_FCS:   state_d = S_IFG;
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase
   end

   assign ip_hdr  = {16'h4500, IP_LEN, id_q, 16'h4000, 16'h4011,
                     csum_q, SRC_IP, DST_IP};
   assign app_hdr = {5'b00000, ch_q, 8'h00, cur_idx};

   // Output logic. The wire byte is registered, so the state machine
   // runs one cycle ahead of e_txd; that lead is what lets the read
   // strobe precede its byte on the wire by exactly one cycle.
   always_comb begin
      txd_d      = 8'h00;
      txen_d     = 1'b0;
      busy_d     = (state_q != S_IDLE);
      fifo_rd_en = '0;
      eth_sh     = ETH_HDR << {cnt_q[3:0], 3'b000};
      ip_sh      = ip_hdr << {cnt_q[4:0], 3'b000};
      udp_sh     = UDP_HDR << {cnt_q[2:0], 3'b000};
      app_sh     = app_hdr << {cnt_q[1:0], 3'b000};
      fcs_sh     = (~crc_q) >> {cnt_q[1:0], 3'b000};
      unique case (state_q)
         S_PRE: begin
            txen_d = 1'b1;
            txd_d  = (cnt_q == CW'(7)) ? 8'hD5 : 8'h55;
         end
         S_ETH: begin
            txen_d = 1'b1;
            txd_d  = eth_sh[111:104];
         end
         S_IP: begin
            txen_d = 1'b1;
            txd_d  = ip_sh[159:152];
         end
         S_UDP: begin
            txen_d = 1'b1;
            txd_d  = udp_sh[63:56];
         end
         S_APP: begin
            txen_d = 1'b1;
            txd_d  = app_sh[31:24];
         end
         S_PAY: begin
            txen_d     = 1'b1;
            txd_d      = pay_byte;
            fifo_rd_en = ch_onehot;
         end
         S_FCS: begin
            txen_d = 1'b1;
            txd_d  = fcs_sh[7:0];
         end
         default: begin
            txen_d = 1'b0;
         end
      endcase
   end

   assign crc_en = (state_q == S_ETH) || (state_q == S_IP) ||
                   (state_q == S_UDP) || (state_q == S_APP) ||
                   (state_q == S_PAY);

   always_comb begin
      ch_d   = ch_q;
      rr_d   = rr_q;
      id_d   = id_q;
      fidx_d = fidx_q;
      csum_d = csum_q;
      crc_d  = crc_q;
      if (state_q == S_ARB) begin
         crc_d  = 32'hFFFF_FFFF;
         csum_d = ip_csum(id_q);
         if (gnt_vld) begin
            ch_d = gnt_ch;
            rr_d = (gnt_ch == 3'(NUM_CH - 1)) ? 3'd0 : gnt_ch + 3'd1;
         end
      end
      if (crc_en) begin
         crc_d = crc_step(crc_q, txd_d);
      end
      if ((state_q == S_FCS) && cnt_last) begin
         id_d = id_q + 16'd1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_onehot[k]) fidx_d[k] = fidx_q[k] + 16'd1;
         end
      end
   end

   always_ff @(posedge e_rxc or negedge reset_n) begin
      if (!reset_n) begin
         ch_q   <= 3'd0;
         rr_q   <= 3'd0;
         id_q   <= 16'h0000;
         fidx_q <= '0;
         csum_q <= 16'h0000;
         crc_q  <= 32'hFFFF_FFFF;
         txd_q  <= 8'h00;
         txen_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         ch_q   <= ch_d;
         rr_q   <= rr_d;
         id_q   <= id_d;
         fidx_q <= fidx_d;
         csum_q <= csum_d;
         crc_q  <= crc_d;
         txd_q  <= txd_d;
         txen_q <= txen_d;
         busy_q <= busy_d;
      end
   end

   assign e_txd  = txd_q;
   assign e_txen = txen_q;
   assign e_txer = 1'b0;
   assign busy   = busy_q;
   assign cur_ch = ch_q;

endmodule

// File: doc/udp_tx_engine.md
UDP_TX_ENGINE -- requirements
Module: udp_tx_engine

Interface
REQ-001 Parameter NUM_CH, default 2: number of input FIFO channels (1..8).
REQ-002 Parameter PAYLOAD_LEN, default 1024: FIFO bytes per frame (even, 18..1468).
REQ-003 Parameter IFG_CYCLES, default 12: idle cycles after each FCS.
REQ-004 Parameters SRC_MAC/DST_MAC (48b), SRC_IP/DST_IP (32b), SRC_PORT/DST_PORT (16b), defaults 00-0A-35-01-FE-C0 / FF-FF-FF-FF-FF-FF, 192.168.0.2 / 192.168.0.3, 8080 / 8080: header constants.
REQ-005 e_rxc  in  1  sole clock, all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 fifo_data  in  8*NUM_CH  read data, channel k at bits [8k+7:8k].
REQ-008 fifo_data_count  in  11*NUM_CH  fill level, channel k at bits [11k+10:11k].
REQ-009 fifo_rd_en  out  NUM_CH  one-hot read strobe.
REQ-010 e_txen  out  1  GMII transmit enable.
REQ-011 e_txd  out  8  GMII transmit data.
REQ-012 e_txer  out  1  GMII transmit error, constant 0.
REQ-013 busy  out  1  high from ARB through IFG.
REQ-014 cur_ch  out  3  channel of frame in progress.

Function
REQ-015 States: IDLE, ARB, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, APP_HDR, PAYLOAD, FCS, IFG.
- IDLE->ARB when any channel has fifo_data_count >= PAYLOAD_LEN.
REQ-016 ARB (1 cycle): round-robin grant starting at (last served + 1) mod NUM_CH; first after reset = channel 0; latch cur_ch; start header checksum.
REQ-017 PREAMBLE: 7 bytes 0x55 then 0xD5 (8 cycles); e_txen high from first 0x55 to last FCS byte, contiguous.
REQ-018 ETH_HDR 14 bytes: DST_MAC, SRC_MAC, 0x0800, MSB first.
REQ-019 IP_HDR 20 bytes: 45 00, total_len = PAYLOAD_LEN+32, id = global frame counter, 40 00, TTL 0x40, proto 0x11, checksum, SRC_IP, DST_IP.
REQ-020 IP checksum = ones'-complement of 16-bit ones'-complement sum of the 10 header words (checksum word as 0), end-around carries folded; value ready before first IP_HDR byte.
REQ-021 UDP_HDR 8 bytes: SRC_PORT, DST_PORT, length = PAYLOAD_LEN+12, checksum 0x0000.
REQ-022 APP_HDR 4 bytes: {5'b0, cur_ch}, 0x00, per-channel 16-bit frame_index MSB first.
REQ-023 PAYLOAD: exactly PAYLOAD_LEN reads; fifo_rd_en[cur_ch] asserted cycle n -> that byte on e_txd cycle n+1; first strobe during last APP_HDR byte; no strobes on other channels.
REQ-024 CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final inversion) over first DST_MAC byte through last payload byte; FCS 4 bytes, least significant byte first.
REQ-025 IFG: e_txen=0, e_txd=0 for IFG_CYCLES cycles, then IDLE; no grant during IFG.
REQ-026 After FCS: frame_index[cur_ch] and global id increment, 16-bit wrap 0xFFFF->0x0000.
REQ-027 Total e_txen-high cycles per frame = PAYLOAD_LEN+58.
REQ-028 fifo_data_count changes after ARB do not affect the frame in progress; count is trusted (no underrun check).
REQ-029 Simultaneous eligible channels: only round-robin winner served; others wait.

Reset
REQ-030 reset_n low at any time, including mid-frame: next state IDLE immediately; e_txen, e_txd, e_txer, fifo_rd_en, busy, cur_ch = 0; all frame_index, global id = 0; round-robin pointer so next grant is channel 0; CRC = 0xFFFFFFFF.
REQ-031 After release, no frame starts before first rising edge with reset_n high.

Verification
REQ-032 NUM_CH=1, PAYLOAD_LEN=18, count=18, data 0x00..0x11 -> 76-byte burst; IP total_len 50, UDP len 30, FCS matches reference CRC-32, IP checksum verifies to 0xFFFF.
REQ-033 NUM_CH=2, both counts >= PAYLOAD_LEN continuously -> grants 0,1,0,1; APP_HDR ch bytes alternate; each channel index 0,0,1,1; id 0,1,2,3; gap exactly IFG_CYCLES.
REQ-034 Channel 1 only eligible, channel 0 count = PAYLOAD_LEN-1 -> channel 1 served; fifo_rd_en[0] never asserts; exactly PAYLOAD_LEN strobes on [1].
REQ-035 Preset frame_index to 0xFFFF via 65535 frames (or force) -> next frame carries 0xFFFF, following carries 0x0000.
REQ-036 reset_n pulsed low during PAYLOAD byte 100 -> e_txen low asynchronously, fifo_rd_en 0; after release first frame: channel 0, index 0, id 0, correct FCS.
